// File: rtl/gc_mq_pkg.sv
// Shared types and constants for the multi-queue gate controller.
package gc_mq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        JUDGE = 2'd1,
        HOLD  = 2'd2
    } gc_state_t;

    localparam int unsigned DEF_TB_SIZE   = 2047;
    localparam int unsigned DEF_TB_PERIOD = 100;
    localparam int unsigned DEF_USEDW_TH  = 20;

    // Extra bits carried by token arithmetic so refill cannot wrap before saturation.
    localparam int unsigned TOKEN_GUARD = 2;

    // Counter width for a counter running 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gc_token_bucket.sv
// Per-queue token bucket: refill on the shared tick, charge on an accepted read,
// flag a discard when a read arrives without enough tokens.
module gc_token_bucket
    import gc_mq_pkg::*;
#(
    parameter int unsigned TOKEN_W = 12,
    parameter int unsigned LEN_W   = 11,
    parameter int unsigned TB_SIZE = DEF_TB_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               rden,
    input  logic [LEN_W-1:0]   pkt_len,
    input  logic [TOKEN_W-1:0] rate,
    output logic [TOKEN_W-1:0] rt,
    output logic               discard
);

    localparam int unsigned CMP_W = (LEN_W > TOKEN_W) ? LEN_W : TOKEN_W;
    localparam int unsigned EXT_W = CMP_W + TOKEN_GUARD;

    logic [EXT_W-1:0] rt_ext;
    logic [EXT_W-1:0] len_ext;
    logic [EXT_W-1:0] fill;
    logic [EXT_W-1:0] cost;
    logic [EXT_W-1:0] rt_d;
    logic             enough;

    // Next token count: refill saturates first, then the accepted packet is charged,
    // so a packet read on a tick is never absorbed by the saturation clamp.
    always_comb begin
        rt_ext  = EXT_W'(rt);
        len_ext = EXT_W'(pkt_len);
        enough  = (rt_ext >= len_ext);
        cost    = (rden && enough) ? len_ext : '0;
        fill    = rt_ext + EXT_W'(rate);
        if (fill > EXT_W'(TB_SIZE)) begin
            fill = EXT_W'(TB_SIZE);
        end
        rt_d = (tick ? fill : rt_ext) - cost;
    end

    // Bucket register and one-cycle discard pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rt      <= '0;
            discard <= 1'b0;
        end else begin
            rt      <= TOKEN_W'(rt_d);
            discard <= rden && !enough;
        end
    end

endmodule

// File: rtl/gc_mq.sv
// Multi-queue gate controller: combines gate state, port backpressure and
// token buckets into a held, handshaked schedule-valid vector for TS.
module gc_mq
    import gc_mq_pkg::*;
#(
    parameter int unsigned     NUM_Q     = 8,
    parameter int unsigned     NUM_PORT  = 4,
    parameter int unsigned     PORT_W    = 2,
    parameter int unsigned     USEDW_W   = 8,
    parameter int unsigned     USEDW_TH  = DEF_USEDW_TH,
    parameter int unsigned     LEN_W     = 11,
    parameter int unsigned     TOKEN_W   = 12,
    parameter int unsigned     TB_SIZE   = DEF_TB_SIZE,
    parameter int unsigned     TB_PERIOD = DEF_TB_PERIOD,
    parameter logic [NUM_Q-1:0] RL_QMASK = 'h04,
    parameter int unsigned     HOLD_TO   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_Q*PORT_W-1:0]     in_gc_md_outport,
    input  logic [NUM_Q-1:0]            in_gc_fifo_empty,
    input  logic [NUM_Q*LEN_W-1:0]      in_gc_pkt_len,
    input  logic [NUM_Q-1:0]            in_gc_gate_state,
    input  logic [NUM_Q*TOKEN_W-1:0]    in_gc_rate_limit,
    input  logic                        in_gc_pkt_valid,
    input  logic [NUM_PORT*USEDW_W-1:0] pktout_usedw,
    input  logic [NUM_Q-1:0]            in_gc_rden,
    output logic [NUM_Q-1:0]            out_gc_schedule_valid,
    output logic [NUM_Q-1:0]            out_gc_bandwidth_discard
);

    localparam int unsigned TICK_W = cnt_w(TB_PERIOD);
    localparam int unsigned HOLD_W = cnt_w(HOLD_TO);
    localparam int unsigned CMP_W  = (LEN_W > TOKEN_W) ? LEN_W : TOKEN_W;

    logic [TICK_W-1:0]              tick_q;
    logic                           tick;
    logic [NUM_Q-1:0][TOKEN_W-1:0]  rt;
    logic [NUM_Q-1:0]               discard;
    logic [NUM_Q-1:0]               elig;

    gc_state_t         state_q, state_d;
    logic [NUM_Q-1:0]  valid_q, valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              init_q, init_d;

    assign tick = (tick_q == TICK_W'(TB_PERIOD - 1));

    // Shared refill tick counter, 0..TB_PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else if (tick) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_Q; i++) begin : g_q
        if (RL_QMASK[i]) begin : g_rl
            gc_token_bucket #(
                .TOKEN_W (TOKEN_W),
                .LEN_W   (LEN_W),
                .TB_SIZE (TB_SIZE)
            ) u_tb (
                .clk     (clk),
                .rst     (rst),
                .tick    (tick),
                .rden    (in_gc_rden[i]),
                .pkt_len (in_gc_pkt_len[i*LEN_W +: LEN_W]),
                .rate    (in_gc_rate_limit[i*TOKEN_W +: TOKEN_W]),
                .rt      (rt[i]),
                .discard (discard[i])
            );
        end else begin : g_free
            assign rt[i]      = '0;
            assign discard[i] = 1'b0;
        end
    end

    assign out_gc_bandwidth_discard = discard;
    assign out_gc_schedule_valid    = valid_q;

    // Per-queue eligibility; an out-of-range outport matches no port and blocks the queue.
    always_comb begin
        logic port_ok;
        logic token_ok;
        elig = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            port_ok = 1'b0;
            for (int unsigned p = 0; p < NUM_PORT; p++) begin
                if ((in_gc_md_outport[i*PORT_W +: PORT_W] == PORT_W'(p)) &&
                    (pktout_usedw[p*USEDW_W +: USEDW_W] <= USEDW_W'(USEDW_TH))) begin
                    port_ok = 1'b1;
                end
            end
            token_ok = !RL_QMASK[i] ||
                       (CMP_W'(rt[i]) >= CMP_W'(in_gc_pkt_len[i*LEN_W +: LEN_W]));
            elig[i] = !in_gc_fifo_empty[i] && in_gc_gate_state[i] && port_ok && token_ok;
        end
    end

    // FSM and valid/hold/init registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            hold_q  <= '0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            init_q  <= init_d;
        end
    end

    // Next-state logic; a read in HOLD takes priority over the hold timeout.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        init_d  = init_q;
        unique case (state_q)
            IDLE: begin
                if (init_q || in_gc_pkt_valid) begin
                    state_d = JUDGE;
                end
            end
            JUDGE: begin
                valid_d = elig;
                if (|elig) begin
                    state_d = HOLD;
                    hold_d  = '0;
                    init_d  = 1'b0;
                end
            end
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (|in_gc_rden) begin
                    valid_d = '0;
                    state_d = IDLE;
                end else if (hold_q == HOLD_W'(HOLD_TO - 1)) begin
                    valid_d = '0;
                    state_d = JUDGE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_gc_mq.sv
// Directed self-checking bench for gc_mq (built with NUM_PORT=3 to exercise out-of-range outports).
module tb_gc_mq;
    import gc_mq_pkg::*;

    localparam int unsigned NQ = 8;
    localparam int unsigned NP = 3;
    localparam int unsigned PW = 2;
    localparam int unsigned UW = 8;
    localparam int unsigned LW = 11;
    localparam int unsigned TW = 12;

    logic               clk;
    logic               rst;
    logic [NQ*PW-1:0]   outport;
    logic [NQ-1:0]      fifo_empty;
    logic [NQ*LW-1:0]   pkt_len;
    logic [NQ-1:0]      gate;
    logic [NQ*TW-1:0]   rate;
    logic               pkt_valid;
    logic [NP*UW-1:0]   usedw;
    logic [NQ-1:0]      rden;
    logic [NQ-1:0]      sched_valid;
    logic [NQ-1:0]      bw_discard;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    gc_mq #(
        .NUM_Q    (NQ),
        .NUM_PORT (NP),
        .PORT_W   (PW),
        .USEDW_W  (UW),
        .LEN_W    (LW),
        .TOKEN_W  (TW)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .in_gc_md_outport         (outport),
        .in_gc_fifo_empty         (fifo_empty),
        .in_gc_pkt_len            (pkt_len),
        .in_gc_gate_state         (gate),
        .in_gc_rate_limit         (rate),
        .in_gc_pkt_valid          (pkt_valid),
        .pktout_usedw             (usedw),
        .in_gc_rden               (rden),
        .out_gc_schedule_valid    (sched_valid),
        .out_gc_bandwidth_discard (bw_discard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        outport    = '0;
        fifo_empty = '1;
        pkt_len    = '0;
        gate       = '0;
        rate       = '0;
        pkt_valid  = 1'b0;
        usedw      = '0;
        rden       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Reset values
        step(2);
        check("rst_valid",   sched_valid, 0);
        check("rst_discard", bw_discard, 0);
        check("rst_state",   dut.state_q, IDLE);
        check("rst_rt2",     dut.rt[2], 0);

        // 1: queue 3 scheduled, held, released by rden
        clear_inputs();
        fifo_empty[3] = 1'b0;
        gate = '1;
        outport[3*PW +: PW] = 2'd1;
        usedw[1*UW +: UW] = 8'd5;
        pkt_len[3*LW +: LW] = 11'd2000;
        do_reset();
        step(2);
        check("t1_valid",      sched_valid, 32'h08);
        check("t1_state_hold", dut.state_q, HOLD);
        step(5);
        check("t1_held",       sched_valid, 32'h08);
        rden = 8'h08;
        step(1);
        rden = '0;
        check("t1_rd_clear",   sched_valid, 0);
        check("t1_idle",       dut.state_q, IDLE);
        check("t1_no_disc",    bw_discard, 0);
        check("t1_rt3_zero",   dut.rt[3], 0);
        step(3);
        check("t1_stay_idle",  sched_valid, 0);

        // 2: backpressure threshold
        clear_inputs();
        fifo_empty[3] = 1'b0;
        gate = '1;
        outport[3*PW +: PW] = 2'd1;
        usedw[1*UW +: UW] = 8'd21;
        do_reset();
        step(4);
        check("t2_bp21",   sched_valid, 0);
        check("t2_judge",  dut.state_q, JUDGE);
        usedw[1*UW +: UW] = 8'd20;
        step(1);
        check("t2_bp20",   sched_valid, 32'h08);

        // 3: token bucket refill, consume, discard
        clear_inputs();
        fifo_empty[2] = 1'b0;
        gate = '1;
        pkt_len[2*LW +: LW] = 11'd64;
        rate[2*TW +: TW] = 12'd100;
        do_reset();
        step(99);
        check("t3_rt_pre",    dut.rt[2], 0);
        check("t3_val_pre",   sched_valid, 0);
        step(1);
        check("t3_rt_tick",   dut.rt[2], 100);
        step(1);
        check("t3_val_tok",   sched_valid, 32'h04);
        rden = 8'h04;
        step(1);
        rden = '0;
        check("t3_rt_cons",   dut.rt[2], 36);
        check("t3_no_disc",   bw_discard, 0);
        pkt_len[2*LW +: LW] = 11'd200;
        rden = 8'h04;
        step(1);
        rden = '0;
        check("t3_disc",      bw_discard, 32'h04);
        check("t3_rt_keep",   dut.rt[2], 36);
        step(1);
        check("t3_disc_end",  bw_discard, 0);
        check("t3_rt_keep2",  dut.rt[2], 36);

        // 4: saturation, tick and consume in the same cycle
        clear_inputs();
        fifo_empty[2] = 1'b0;
        gate = '1;
        pkt_len[2*LW +: LW] = 11'd64;
        rate[2*TW +: TW] = 12'd4000;
        do_reset();
        step(100);
        check("t4_sat1",      dut.rt[2], 2047);
        step(200);
        check("t4_sat3",      dut.rt[2], 2047);
        step(99);
        rden = 8'h04;
        step(1);
        rden = '0;
        check("t4_tick_cons", dut.rt[2], 1983);
        check("t4_no_disc",   bw_discard, 0);
        step(1);
        check("t4_hold_rt",   dut.rt[2], 1983);

        // 5: hold timeout, re-judge with gate closed, reset in HOLD
        clear_inputs();
        fifo_empty[0] = 1'b0;
        gate = '1;
        do_reset();
        step(2);
        check("t5_valid",     sched_valid, 32'h01);
        step(15);
        check("t5_last_hold", sched_valid, 32'h01);
        gate[0] = 1'b0;
        step(1);
        check("t5_timeout",   sched_valid, 0);
        check("t5_rejudge",   dut.state_q, JUDGE);
        step(4);
        check("t5_gate_shut", sched_valid, 0);
        gate[0] = 1'b1;
        step(1);
        check("t5_reopen",    sched_valid, 32'h01);
        rst = 1'b1;
        step(1);
        check("t5_rst_valid", sched_valid, 0);
        check("t5_rst_disc",  bw_discard, 0);
        check("t5_rst_state", dut.state_q, IDLE);
        rst = 1'b0;

        // 6: out-of-range outport, pkt_valid ignored outside IDLE
        clear_inputs();
        fifo_empty[5] = 1'b0;
        gate = '1;
        outport[5*PW +: PW] = 2'd3;
        do_reset();
        step(6);
        check("t6_badport",   sched_valid, 0);
        fifo_empty[3] = 1'b0;
        outport[3*PW +: PW] = 2'd1;
        step(1);
        check("t6_q3_only",   sched_valid, 32'h08);
        pkt_valid = 1'b1;
        step(1);
        pkt_valid = 1'b0;
        rden = 8'h08;
        step(1);
        rden = '0;
        check("t6_rd_clear",  sched_valid, 0);
        step(3);
        check("t6_no_rejudge", sched_valid, 0);
        check("t6_idle",      dut.state_q, IDLE);
        pkt_valid = 1'b1;
        step(1);
        pkt_valid = 1'b0;
        check("t6_arm",       dut.state_q, JUDGE);
        step(1);
        check("t6_rearmed",   sched_valid, 32'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
